switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter WIDTH, default 4: number of switch bits; matches io_bus_if WIDTH.
REQ-002 Parameter STABLE_CYCLES, default 1_000_000: clk cycles a raw level must hold before it is accepted; legal range 2..2^24-1.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 n_reset  input  1  reset, asynchronous, active-low.
REQ-005 raw_switch  input  WIDTH  asynchronous, bouncing pin level.
REQ-006 switch  output  WIDTH  debounced level; feeds io_bus.switch.
REQ-007 rise  output  WIDTH  one-cycle pulse per bit when that bit's debounced level goes 0->1.
REQ-008 fall  output  WIDTH  one-cycle pulse per bit when that bit's debounced level goes 1->0.
REQ-009 event_pending  output  WIDTH  sticky flag per bit, set by rise.
REQ-010 event_ack  input  WIDTH  per-bit clear request for event_pending; level-sampled each cycle.

Function
REQ-011 Each raw_switch bit SHALL pass through a 2-flop synchronizer before any other logic; synchronizer latency is 2 cycles.
REQ-012 Each bit SHALL run an independent FSM with states LOW, CHECK_HIGH, HIGH, CHECK_LOW.
REQ-013 LOW: synchronized input 1 -> CHECK_HIGH and load counter with 1; otherwise stay.
REQ-014 CHECK_HIGH: input 0 -> LOW and clear counter (bounce rejected); input 1 and counter == STABLE_CYCLES-1 -> HIGH; otherwise counter increments.
REQ-015 HIGH and CHECK_LOW SHALL mirror REQ-013/014 with the polarity inverted.
REQ-016 switch[i] SHALL be 1 exactly in states HIGH and CHECK_LOW; it changes on the same edge as the FSM enters HIGH or LOW.
REQ-017 Total latency from a clean raw edge to switch change SHALL be 2 + STABLE_CYCLES cycles.
REQ-018 rise[i]/fall[i] SHALL be asserted for exactly the one cycle after switch[i] changes; both are never high together for one bit.
REQ-019 Counter width SHALL be $clog2(STABLE_CYCLES); it never wraps, because it is compared and stopped at STABLE_CYCLES-1.
REQ-020 event_pending[i] SHALL set on rise[i] and clear on event_ack[i]; if rise[i] and event_ack[i] coincide, set wins (no event lost).
REQ-021 event_ack on a bit whose event_pending is 0 SHALL have no effect.
REQ-022 Bits SHALL not interact; simultaneous activity on all bits is handled independently in the same cycle.

Reset
REQ-023 On n_reset low, asynchronously: synchronizer flops 0, every FSM in LOW, counters 0, switch 0, rise 0, fall 0, event_pending 0.
REQ-024 Reset asserted mid-CHECK_HIGH SHALL abandon the qualification; after release a held-high input requires the full 2 + STABLE_CYCLES again and then produces one rise.
REQ-025 Reset release SHALL produce no rise/fall pulse by itself.

Structure
REQ-026 Package switch_pkg SHALL hold the FSM state enum typedef (LOW, CHECK_HIGH, HIGH, CHECK_LOW) and the synchronizer depth constant (2).
REQ-027 One sub-module debounce_bit (synchronizer, FSM, counter, edge pulses for one bit) SHALL be instantiated WIDTH times by a generate loop; event_pending logic stays in the top of this block.
REQ-028 The block SHALL run on the fast board clock, ahead of the prescaler domain; crossing into the slow domain is outside this block.

Verification (bench uses STABLE_CYCLES = 8)
REQ-029 Clean press: raw_switch 0000 -> 0001 held -> switch = 0001 exactly 10 cycles later, rise = 0001 for one cycle, event_pending = 0001.
REQ-030 Bounce: bit 1 toggles 1/0 every 3 cycles for 30 cycles, then holds 1 -> switch[1] stays 0 through the bounce, goes 1 ten cycles after the last toggle, exactly one rise.
REQ-031 Release: from switch = 0001, raw 0000 held -> switch = 0000 after 10 cycles, fall = 0001 for one cycle, event_pending unchanged.
REQ-032 Ack race: event_ack[2] held while a new rise[2] occurs -> event_pending[2] = 1 afterward; dropping event_ack and reasserting for one cycle -> 0.
REQ-033 Reset mid-qualification: raw 1111 held, n_reset low 5 cycles after edge for 3 cycles -> all outputs 0 immediately; after release switch = 1111 ten cycles later, one rise per bit.
REQ-034 All bits at once: raw 0000 -> 1111 -> switch 1111 and rise 1111 on the same cycle.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// Shared types and constants for the switch debouncer block.
// Per-bit qualification state and synchronizer depth live here so the bench and RTL agree.
package switch_pkg;

   typedef enum logic [1:0] {
      LOW        = 2'd0,
      CHECK_HIGH = 2'd1,
      HIGH       = 2'd2,
      CHECK_LOW  = 2'd3
   } db_state_t;

   localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One-bit debouncer: 2-flop synchronizer, qualification FSM with run counter, edge pulses.
// Latency 2 + STABLE_CYCLES from a clean raw edge to level change; no backpressure.
module debounce_bit
   import switch_pkg::*;
#(
   parameter int STABLE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic n_reset,
   input  logic raw_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int             CW   = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0]  ONE  = CW'(1);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  din;
   db_state_t             state;
   logic [CW-1:0]         cnt;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], raw_in};
      end
   end

   assign din = sync_q[SYNC_DEPTH-1];

   // cnt holds the number of consecutive qualifying samples seen so far; it
   // stops at LAST, so it never needs to represent STABLE_CYCLES itself.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= LOW;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            LOW: begin
               if (din) begin
                  state <= CHECK_HIGH;
                  cnt   <= ONE;
               end
            end
            CHECK_HIGH: begin
               if (!din) begin
                  state <= LOW;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= HIGH;
                  cnt   <= '0;
                  level <= 1'b1;
                  rise  <= 1'b1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            HIGH: begin
               if (!din) begin
                  state <= CHECK_LOW;
                  cnt   <= ONE;
               end
            end
            CHECK_LOW: begin
               if (din) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= LOW;
                  cnt   <= '0;
                  level <= 1'b0;
                  fall  <= 1'b1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            default: begin
               state <= LOW;
               cnt   <= '0;
               level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// Multi-bit switch debouncer with per-bit rise/fall pulses and sticky rise events.
// Latency 2 + STABLE_CYCLES per bit; no backpressure, event_ack clears pending flags.
module switch_debouncer
   import switch_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic [WIDTH-1:0] raw_switch,
   output logic [WIDTH-1:0] switch,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] event_pending,
   input  logic [WIDTH-1:0] event_ack
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_bit (
         .clk     (clk),
         .n_reset (n_reset),
         .raw_in  (raw_switch[i]),
         .level   (switch[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
      );
   end

   // Set has priority over ack so a rise coinciding with an ack is never lost.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         event_pending <= '0;
      end else begin
         event_pending <= (event_pending & ~event_ack) | rise;
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized and directed bench for switch_debouncer against a sample-history reference model.
module tb_switch_debouncer;

   localparam int W = 4;
   localparam int S = 8;
   localparam int LAT = S + 2;

   logic         clk = 1'b0;
   logic         n_reset;
   logic [W-1:0] raw_switch;
   logic [W-1:0] switch;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic [W-1:0] event_pending;
   logic [W-1:0] event_ack;

   int n_checks = 0;
   int n_errors = 0;

   switch_debouncer #(
      .WIDTH         (W),
      .STABLE_CYCLES (S)
   ) dut (
      .clk           (clk),
      .n_reset       (n_reset),
      .raw_switch    (raw_switch),
      .switch        (switch),
      .rise          (rise),
      .fall          (fall),
      .event_pending (event_pending),
      .event_ack     (event_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a bit's debounced level flips once the last S synchronized
   // samples all differ from it; synchronized sample = raw sampled two edges earlier.
   logic [W-1:0] hist [0:S+1];
   logic [W-1:0] m_sw, m_rise, m_fall, m_pend;

   always @(posedge clk or negedge n_reset) begin
      logic [W-1:0] flip;
      bit           all_diff;
      if (!n_reset) begin
         for (int k = 0; k <= S + 1; k++) hist[k] = '0;
         m_sw = '0; m_rise = '0; m_fall = '0; m_pend = '0;
      end else begin
         for (int k = S + 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = raw_switch;
         flip = '0;
         for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= S + 1; k++)
               if (hist[k][i] == m_sw[i]) all_diff = 1'b0;
            flip[i] = all_diff;
         end
         m_pend = (m_pend & ~event_ack) | m_rise;
         m_rise = flip & ~m_sw;
         m_fall = flip & m_sw;
         m_sw   = m_sw ^ flip;
      end
   end

   always @(negedge clk) begin
      check("model_switch", switch, m_sw);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
      check("model_pending", event_pending, m_pend);
   end

   int rise_cnt [W];
   initial for (int i = 0; i < W; i++) rise_cnt[i] = 0;
   always @(negedge clk) for (int i = 0; i < W; i++) rise_cnt[i] += int'(rise[i]);

   task automatic wait_sw(input logic [W-1:0] target, input int limit, output int cycles);
      cycles = 0;
      while (cycles < limit) begin
         @(posedge clk); #1;
         cycles++;
         if (switch == target) break;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int cyc;
      int snap [W];
      bit stayed_low;

      n_reset = 1'b0; raw_switch = '0; event_ack = '0;
      idle(3);
      check("reset_switch", switch, 0);
      check("reset_pending", event_pending, 0);
      n_reset = 1'b1;
      idle(4);
      check("release_no_pulse", {rise, fall}, 0);

      // Clean press on bit 0
      raw_switch = 4'b0001;
      wait_sw(4'b0001, 40, cyc);
      check("press_latency", cyc, LAT);
      check("press_rise", rise, 4'b0001);
      @(posedge clk); #1;
      check("press_rise_gone", rise, 0);
      check("press_pending", event_pending, 4'b0001);

      // Bounce on bit 1: toggles every 3 cycles for 30 cycles
      @(negedge clk);
      for (int i = 0; i < W; i++) snap[i] = rise_cnt[i];
      stayed_low = 1'b1;
      for (int t = 0; t < 30; t++) begin
         raw_switch[1] = ((t / 3) % 2 == 0);
         @(negedge clk);
         if (switch[1]) stayed_low = 1'b0;
      end
      raw_switch[1] = 1'b1;
      wait_sw(4'b0011, 40, cyc);
      check("bounce_stayed_low", 32'(stayed_low), 1);
      check("bounce_latency", cyc, LAT);
      idle(5);
      check("bounce_one_rise", rise_cnt[1] - snap[1], 1);

      // Release bit 0
      raw_switch = 4'b0010;
      wait_sw(4'b0010, 40, cyc);
      check("release_latency", cyc, LAT);
      check("release_fall", fall, 4'b0001);
      @(posedge clk); #1;
      check("release_pending_kept", event_pending, 4'b0011);

      // Ack race on bit 2
      @(negedge clk); event_ack = 4'b1111;
      @(negedge clk); event_ack = 4'b0100;
      check("ack_cleared_all", event_pending, 0);
      raw_switch = 4'b0110;
      wait_sw(4'b0110, 40, cyc);
      check("race_latency", cyc, LAT);
      @(posedge clk); #1;
      check("race_set_wins", event_pending[2], 1);
      @(negedge clk); event_ack = 4'b0000;
      @(negedge clk); event_ack = 4'b0100;
      @(negedge clk); event_ack = 4'b0000;
      check("race_ack_clears", event_pending[2], 0);

      // Reset mid-qualification
      raw_switch = 4'b0000;
      wait_sw(4'b0000, 40, cyc);
      check("drop_all", switch, 0);
      idle(2);
      raw_switch = 4'b1111;
      repeat (5) @(posedge clk);
      #2 n_reset = 1'b0;
      #1;
      check("midrst_outputs", {switch, rise, fall, event_pending}, 0);
      idle(3);
      for (int i = 0; i < W; i++) snap[i] = rise_cnt[i];
      n_reset = 1'b1;
      wait_sw(4'b1111, 40, cyc);
      check("midrst_latency", cyc, LAT);
      check("midrst_rise", rise, 4'b1111);
      idle(5);
      for (int i = 0; i < W; i++) check("midrst_one_rise", rise_cnt[i] - snap[i], 1);

      // All bits released then pressed together
      raw_switch = 4'b0000;
      wait_sw(4'b0000, 40, cyc);
      check("all_fall_latency", cyc, LAT);
      check("all_fall", fall, 4'b1111);
      idle(3);
      raw_switch = 4'b1111;
      wait_sw(4'b1111, 40, cyc);
      check("all_rise_latency", cyc, LAT);
      check("all_rise", rise, 4'b1111);

      // Random bouncing and acks, checked cycle by cycle against the model
      for (int t = 0; t < 4000; t++) begin
         @(negedge clk);
         for (int i = 0; i < W; i++)
            if ($urandom_range(11) == 0) raw_switch[i] = ~raw_switch[i];
         event_ack = W'($urandom_range(15)) & W'($urandom_range(15));
         if (t == 2000) begin
            #2 n_reset = 1'b0;
            #3 n_reset = 1'b1;
         end
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

endmodule
